// File: rtl/sram_fifo_ctrl.sv
// SRAM-backed FIFO controller: entries are queued in an external two-port SRAM and
// prefetched into a 2-entry output buffer that hides the one-cycle SRAM read latency.
module sram_fifo_ctrl #(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 8
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] out_data,
    output logic [DEPTH+1:0]    count,
    output logic [BITWIDTH-1:0] sram_D,
    output logic                sram_WEB,
    output logic [BITWIDTH-1:0] sram_BWEB,
    output logic [DEPTH-1:0]    sram_AA,
    output logic                sram_REB,
    output logic [DEPTH-1:0]    sram_AB,
    input  logic [BITWIDTH-1:0] sram_Q
);

    localparam logic [DEPTH:0] SRAM_CAP = {1'b1, {DEPTH{1'b0}}};

    logic [DEPTH-1:0]    wptr;
    logic [DEPTH-1:0]    rptr;
    logic [DEPTH:0]      sram_cnt;
    logic                rd_pending;
    logic [1:0]          buf_cnt;
    logic [BITWIDTH-1:0] buf_head;
    logic [BITWIDTH-1:0] buf_tail;
    logic                push;
    logic                pop;
    logic [2:0]          buf_occ;

    assign in_ready  = RSTN && (sram_cnt < SRAM_CAP);
    assign push      = in_valid && in_ready;
    assign out_valid = (buf_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = buf_head;

    assign sram_WEB  = push;
    assign sram_AA   = wptr;
    assign sram_D    = in_data;
    assign sram_BWEB = '1;

    // Buffer slots that will be taken once this cycle's pop and any pending capture settle.
    assign buf_occ  = 3'(buf_cnt) + 3'(rd_pending) - 3'(pop);
    assign sram_REB = (sram_cnt != '0) && (buf_occ < 3'd2);
    assign sram_AB  = rptr;

    assign count = (DEPTH+2)'(sram_cnt) + (DEPTH+2)'(rd_pending) + (DEPTH+2)'(buf_cnt);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wptr       <= '0;
            rptr       <= '0;
            sram_cnt   <= '0;
            rd_pending <= 1'b0;
            buf_cnt    <= '0;
        end else begin
            if (push)
                wptr <= wptr + DEPTH'(1);
            if (sram_REB)
                rptr <= rptr + DEPTH'(1);
            sram_cnt   <= sram_cnt + (DEPTH+1)'(push) - (DEPTH+1)'(sram_REB);
            rd_pending <= sram_REB;
            buf_cnt    <= buf_cnt + 2'(rd_pending) - 2'(pop);
        end
    end

    // Head is the oldest entry; a capture lands in the head slot if it becomes empty.
    always_ff @(posedge CLK) begin
        if (rd_pending) begin
            if (buf_cnt == 2'd0 || (buf_cnt == 2'd1 && pop)) begin
                buf_head <= sram_Q;
            end else begin
                if (pop)
                    buf_head <= buf_tail;
                buf_tail <= sram_Q;
            end
        end else if (pop) begin
            buf_head <= buf_tail;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl (DEPTH=3) with a behavioural 1-cycle-latency SRAM
// and a queue scoreboard tracking expected order and occupancy.
module tb_sram_fifo_ctrl;

    localparam int BW = 32;
    localparam int DP = 3;

    logic          CLK;
    logic          RSTN;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic [DP+1:0] count;
    logic [BW-1:0] sram_D;
    logic          sram_WEB;
    logic [BW-1:0] sram_BWEB;
    logic [DP-1:0] sram_AA;
    logic          sram_REB;
    logic [DP-1:0] sram_AB;
    logic [BW-1:0] sram_Q;

    logic [BW-1:0] mem [2**DP];

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] exp_q [$];
    int            mcnt = 0;
    int            npush = 0;
    int            npop  = 0;

    logic          s_web, s_reb, s_push, s_pop;
    logic [DP-1:0] s_aa, s_ab;
    logic [BW-1:0] s_d, s_od;
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_od;

    sram_fifo_ctrl #(.BITWIDTH(BW), .DEPTH(DP)) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .sram_D   (sram_D),
        .sram_WEB (sram_WEB),
        .sram_BWEB(sram_BWEB),
        .sram_AA  (sram_AA),
        .sram_REB (sram_REB),
        .sram_AB  (sram_AB),
        .sram_Q   (sram_Q)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (sram_WEB)
            mem[sram_AA] <= sram_D;
        if (sram_REB)
            sram_Q <= mem[sram_AB];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, snapshot before the edge, update the model after it.
    task automatic cyc(input logic iv, input logic [BW-1:0] d, input logic ordy);
        logic [BW-1:0] e;
        @(negedge CLK);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        s_web  = sram_WEB;
        s_reb  = sram_REB;
        s_aa   = sram_AA;
        s_ab   = sram_AB;
        s_d    = sram_D;
        s_push = in_valid && in_ready;
        s_pop  = out_valid && out_ready;
        s_od   = out_data;
        check("collide", sram_WEB && sram_REB && (sram_AA == sram_AB), 1'b0);
        if (prev_stall)
            check("stable", out_data, prev_od);
        prev_stall = out_valid && !out_ready;
        prev_od    = out_data;
        @(posedge CLK);
        #1;
        if (s_push) begin
            exp_q.push_back(d);
            mcnt++;
            npush++;
        end
        if (s_pop) begin
            check("underflow", exp_q.size() == 0, 1'b0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("data", s_od, e);
            end
            mcnt--;
            npop++;
        end
        check("count", count, mcnt);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, '0, 1'b1);
        check("drain_count", count, 0);
        check("drain_model", exp_q.size(), 0);
        check("drain_ovalid", out_valid, 1'b0);
    endtask

    initial begin
        int base;
        int late_pops;
        int pushed;

        // Reset state, with in_valid high to confirm the write is gated
        RSTN      = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1111_1111;
        out_ready = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_count", count, 0);
        check("rst_web", sram_WEB, 1'b0);
        check("rst_reb", sram_REB, 1'b0);
        check("bweb", sram_BWEB, 32'hFFFF_FFFF);
        @(negedge CLK);
        in_valid = 1'b0;
        RSTN     = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 1'b1);

        // Single entry latency
        cyc(1'b1, 32'hA5A5_A5A5, 1'b1);
        check("e0_web", s_web, 1'b1);
        check("e0_aa", s_aa, 0);
        check("e0_d", s_d, 32'hA5A5_A5A5);
        check("e0_reb", s_reb, 1'b0);
        check("e0_ovalid", out_valid, 1'b0);
        cyc(1'b0, '0, 1'b1);
        check("e1_reb", s_reb, 1'b1);
        check("e1_ab", s_ab, 0);
        check("e1_ovalid", out_valid, 1'b0);
        check("e1_count", count, 1);
        cyc(1'b0, '0, 1'b1);
        check("e2_reb", s_reb, 1'b0);
        check("e2_ovalid", out_valid, 1'b1);
        check("e2_odata", out_data, 32'hA5A5_A5A5);
        cyc(1'b0, '0, 1'b1);
        check("e3_popped", s_pop, 1'b1);
        check("e3_count", count, 0);
        check("e3_ovalid", out_valid, 1'b0);

        // Fill with out_ready low: 10 accepted, 11th refused
        base = npush;
        for (int i = 0; i < 11; i++)
            cyc(1'b1, 32'h100 + i, 1'b0);
        check("fill_accepted", npush - base, 10);
        check("fill_web11", s_web, 1'b0);
        check("fill_in_ready", in_ready, 1'b0);
        check("fill_count", count, 10);
        cyc(1'b1, 32'h1FF, 1'b0);
        cyc(1'b1, 32'h1FF, 1'b0);
        check("fill_hold", count, 10);
        drain(20);

        // Streaming: one push and one pop per cycle after the pipeline fills
        late_pops = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1'b1, $urandom, 1'b1);
            if (i >= 5 && s_pop)
                late_pops++;
        end
        check("stream_rate", late_pops, 995);
        drain(20);

        // Wrap-around under random valid/ready
        pushed = 0;
        for (int i = 0; i < 400 && pushed < 20; i++) begin
            cyc(1'($urandom_range(0, 1)), 32'h2000 + pushed, 1'($urandom_range(0, 1)));
            if (s_push)
                pushed++;
        end
        check("wrap_pushed", pushed, 20);
        drain(30);

        // Backpressure: out_ready toggling every cycle
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 32'h3000 + i, (i % 2) == 0);
            check("buf_cnt_max", dut.buf_cnt <= 2'd2, 1'b1);
        end
        drain(30);

        // Reset mid-stream with five entries held
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 32'h4000 + i, 1'b0);
        check("pre_rst_count", count, 5);
        @(negedge CLK);
        in_valid = 1'b0;
        RSTN     = 1'b0;
        #1;
        check("mid_rst_ovalid", out_valid, 1'b0);
        check("mid_rst_count", count, 0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_reb", sram_REB, 1'b0);
        @(negedge CLK);
        RSTN = 1'b1;
        exp_q.delete();
        mcnt       = 0;
        prev_stall = 1'b0;
        cyc(1'b1, 32'hDEAD_BEEF, 1'b1);
        cyc(1'b1, 32'h1234_5678, 1'b1);
        cyc(1'b0, '0, 1'b1);
        check("post_rst_ovalid", out_valid, 1'b1);
        check("post_rst_first", out_data, 32'hDEAD_BEEF);
        drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
